// File: rtl/spi_pkg.sv
// Shared definitions for the SPI slave: cfg bit positions, FSM state encoding
// and the default word width.
package spi_pkg;

  localparam int CFG_DIR  = 0;
  localparam int CFG_CPOL = 1;
  localparam int CFG_CPHA = 2;

  localparam int DEFAULT_DATA_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchroniser for one asynchronous SPI pin, plus a registered level
// and one-cycle rise/fall pulses that are aligned with that level.
module spi_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_d,
  output logic o_q,
  output logic o_rise,
  output logic o_fall
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_prev;
  logic                   r_rise;
  logic                   r_fall;

  // The pulses update on the same edge as r_prev, so o_q and o_rise/o_fall describe the same pin sample.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= '0;
      r_prev <= 1'b0;
      r_rise <= 1'b0;
      r_fall <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_d};
      r_prev <= r_sync[SYNC_STAGES-1];
      r_rise <= r_sync[SYNC_STAGES-1] & ~r_prev;
      r_fall <= ~r_sync[SYNC_STAGES-1] & r_prev;
    end
  end

  assign o_q    = r_prev;
  assign o_rise = r_rise;
  assign o_fall = r_fall;

endmodule

// File: rtl/spi_slave.sv
// Oversampling SPI slave: receives words with a valid/ack handshake and returns a preloaded word on miso.
// Define SPI_SLAVE_ERR_CNT_EN to add the saturating o_err_cnt output.
module spi_slave
  import spi_pkg::*;
#(
  parameter int DATA_WIDTH  = DEFAULT_DATA_WIDTH,
  parameter int CNT_WIDTH   = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [2:0]            i_cfg,
  input  logic                  i_sclk,
  input  logic                  i_mosi,
  input  logic                  i_ss,
  output logic                  o_miso,
  input  logic [DATA_WIDTH-1:0] i_tx_data,
  input  logic                  i_tx_req,
  output logic                  o_tx_ack,
  output logic [DATA_WIDTH-1:0] o_rx_data,
  output logic                  o_rx_valid,
  input  logic                  i_rx_ack,
  output logic                  o_overrun
`ifdef SPI_SLAVE_ERR_CNT_EN
  ,
  output logic [7:0]            o_err_cnt
`endif
);

  logic w_sclk_q, w_sclk_rise, w_sclk_fall;
  logic w_mosi, w_mosi_rise, w_mosi_fall;
  logic w_ss, w_ss_rise, w_ss_fall;

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sclk (
    .clk(clk), .rst_n(rst_n), .i_d(i_sclk),
    .o_q(w_sclk_q), .o_rise(w_sclk_rise), .o_fall(w_sclk_fall)
  );

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_mosi (
    .clk(clk), .rst_n(rst_n), .i_d(i_mosi),
    .o_q(w_mosi), .o_rise(w_mosi_rise), .o_fall(w_mosi_fall)
  );

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_ss (
    .clk(clk), .rst_n(rst_n), .i_d(i_ss),
    .o_q(w_ss), .o_rise(w_ss_rise), .o_fall(w_ss_fall)
  );

  logic w_unused;
  assign w_unused = &{1'b0, w_sclk_q, w_mosi_rise, w_mosi_fall};

  state_t                r_state;
  logic [2:0]            r_cfg;
  logic [DATA_WIDTH-1:0] r_hold;
  logic [DATA_WIDTH-1:0] r_tx_sh;
  logic [DATA_WIDTH-1:0] r_rx_sh;
  logic [CNT_WIDTH-1:0]  r_cnt;
  logic                  r_skip;
  logic                  r_miso;
  logic                  r_tx_ack;
  logic [DATA_WIDTH-1:0] r_rx_data;
  logic                  r_rx_valid;
  logic                  r_overrun;

  logic                  w_lead, w_trail;
  logic                  w_sample_edge, w_shift_edge;
  logic [DATA_WIDTH-1:0] w_rx_next;
  logic [DATA_WIDTH-1:0] w_tx_adv;
  logic [CNT_WIDTH-1:0]  w_cnt_inc;
  logic                  w_abort_evt;
  logic                  w_overrun_evt;

  function automatic logic first_bit(input logic [DATA_WIDTH-1:0] word, input logic dir);
    return dir ? word[DATA_WIDTH-1] : word[0];
  endfunction

  assign w_lead        = r_cfg[CFG_CPOL] ? w_sclk_fall : w_sclk_rise;
  assign w_trail       = r_cfg[CFG_CPOL] ? w_sclk_rise : w_sclk_fall;
  assign w_sample_edge = r_cfg[CFG_CPHA] ? w_trail : w_lead;
  assign w_shift_edge  = r_cfg[CFG_CPHA] ? w_lead : w_trail;

  assign w_rx_next = r_cfg[CFG_DIR] ? {r_rx_sh[DATA_WIDTH-2:0], w_mosi}
                                    : {w_mosi, r_rx_sh[DATA_WIDTH-1:1]};
  assign w_tx_adv  = r_cfg[CFG_DIR] ? {r_tx_sh[DATA_WIDTH-2:0], 1'b0}
                                    : {1'b0, r_tx_sh[DATA_WIDTH-1:1]};
  assign w_cnt_inc = r_cnt + 1'b1;

  // ss dropping right after a completed word (no bits of the next one yet) is a normal frame end, not an abort.
  assign w_abort_evt   = (r_state == SHIFT) && w_ss_fall && (r_cnt != '0);
  assign w_overrun_evt = (r_state == DONE) && r_rx_valid && !i_rx_ack;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tx_ack <= 1'b0;
      r_hold   <= '0;
    end else if (i_tx_req && !r_tx_ack) begin
      r_tx_ack <= 1'b1;
      r_hold   <= i_tx_data;
    end else begin
      r_tx_ack <= 1'b0;
    end
  end

  // r_skip swallows the one shift edge per word that would otherwise advance past the freshly loaded first bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_cfg      <= '0;
      r_tx_sh    <= '0;
      r_rx_sh    <= '0;
      r_cnt      <= '0;
      r_skip     <= 1'b0;
      r_miso     <= 1'b0;
      r_rx_data  <= '0;
      r_rx_valid <= 1'b0;
      r_overrun  <= 1'b0;
    end else begin
      if (i_rx_ack && r_rx_valid) begin
        r_rx_valid <= 1'b0;
      end
      case (r_state)
        IDLE: begin
          r_miso <= first_bit(r_hold, i_cfg[CFG_DIR]);
          if (w_ss_rise) begin
            r_cfg   <= i_cfg;
            r_tx_sh <= r_hold;
            r_rx_sh <= '0;
            r_cnt   <= '0;
            r_skip  <= i_cfg[CFG_CPHA];
            r_state <= SHIFT;
          end
        end
        SHIFT: begin
          if (w_ss_fall) begin
            r_state <= IDLE;
          end else if (w_sample_edge) begin
            r_rx_sh <= w_rx_next;
            r_cnt   <= w_cnt_inc;
            if (w_cnt_inc == CNT_WIDTH'(DATA_WIDTH)) begin
              r_state <= DONE;
            end
          end else if (w_shift_edge) begin
            if (r_skip) begin
              r_skip <= 1'b0;
            end else begin
              r_tx_sh <= w_tx_adv;
              r_miso  <= first_bit(w_tx_adv, r_cfg[CFG_DIR]);
            end
          end
        end
        DONE: begin
          r_rx_data  <= r_rx_sh;
          r_rx_valid <= 1'b1;
          r_cnt      <= '0;
          if (w_overrun_evt) begin
            r_overrun <= 1'b1;
          end
          if (w_ss) begin
            r_tx_sh <= r_hold;
            r_rx_sh <= '0;
            r_skip  <= 1'b1;
            r_miso  <= first_bit(r_hold, r_cfg[CFG_DIR]);
            r_state <= SHIFT;
          end else begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

`ifdef SPI_SLAVE_ERR_CNT_EN
  logic [7:0] r_err_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err_cnt <= '0;
    end else if ((w_overrun_evt || w_abort_evt) && (r_err_cnt != 8'hFF)) begin
      r_err_cnt <= r_err_cnt + 8'd1;
    end
  end

  assign o_err_cnt = r_err_cnt;
`endif

  assign o_miso     = r_miso;
  assign o_tx_ack   = r_tx_ack;
  assign o_rx_data  = r_rx_data;
  assign o_rx_valid = r_rx_valid;
  assign o_overrun  = r_overrun;

endmodule

// File: tb/tb_spi_slave.sv
// Directed bench for spi_slave: a table of single-word frames in all four modes
// plus hand-written sequences for abort, overrun, ack-at-done and mid-frame reset.
module tb_spi_slave;

  localparam int HALF = 8;

  logic       clk;
  logic       rst_n;
  logic [2:0] cfg;
  logic       sclk;
  logic       mosi;
  logic       ss;
  logic       miso;
  logic [7:0] txData;
  logic       txReq;
  logic       txAck;
  logic [7:0] rxData;
  logic       rxValid;
  logic       rxAck;
  logic       overrun;
`ifdef SPI_SLAVE_ERR_CNT_EN
  logic [7:0] errCnt;
`endif

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [2:0] cfg;
    logic [7:0] txWord;
    logic [7:0] mosiWord;
    logic [7:0] expRx;
    logic [7:0] expMiso;
    logic       expIdleMiso;
  } vec_t;

  vec_t vecs[4];

  spi_slave dut (
    .clk(clk),
    .rst_n(rst_n),
    .i_cfg(cfg),
    .i_sclk(sclk),
    .i_mosi(mosi),
    .i_ss(ss),
    .o_miso(miso),
    .i_tx_data(txData),
    .i_tx_req(txReq),
    .o_tx_ack(txAck),
    .o_rx_data(rxData),
    .o_rx_valid(rxValid),
    .i_rx_ack(rxAck),
    .o_overrun(overrun)
`ifdef SPI_SLAVE_ERR_CNT_EN
    ,
    .o_err_cnt(errCnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic waitClk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic loadTx(input logic [7:0] value);
    txData = value;
    txReq  = 1'b1;
    waitClk(1);
    checkOutput("tx_ack_pulse", txAck, 1'b1);
    txReq = 1'b0;
    waitClk(1);
    checkOutput("tx_ack_drop", txAck, 1'b0);
  endtask

  task automatic ackRx();
    rxAck = 1'b1;
    waitClk(1);
    rxAck = 1'b0;
    checkOutput("rx_valid_cleared", rxValid, 1'b0);
  endtask

  task automatic waitValid(input string name);
    for (int i = 0; i < 40; i++) begin
      if (rxValid) break;
      waitClk(1);
    end
    checkOutput(name, rxValid, 1'b1);
  endtask

  // Master model: nBits < 8 drops ss mid-word; ackAtDone pulses rx_ack in the slave's DONE cycle of the last word.
  task automatic spiXfer(input logic [2:0] c, input logic [7:0] w0, input logic [7:0] w1,
                         input int nWords, input int nBits, input bit ackAtDone,
                         output logic [7:0] m0, output logic [7:0] m1);
    logic       cpol, cpha, dir;
    logic [7:0] word, cap;
    int         idx;
    cpol = c[1];
    cpha = c[2];
    dir  = c[0];
    m0   = '0;
    m1   = '0;
    cfg  = c;
    sclk = cpol;
    ss   = 1'b0;
    waitClk(HALF);
    ss = 1'b1;
    waitClk(2 * HALF);
    for (int w = 0; w < nWords; w++) begin
      word = (w == 0) ? w0 : w1;
      cap  = '0;
      for (int b = 0; b < nBits; b++) begin
        idx = dir ? 7 - b : b;
        if (!cpha) begin
          mosi = word[idx];
          waitClk(HALF);
          cap[idx] = miso;
          sclk = ~cpol;
        end else begin
          sclk = ~cpol;
          mosi = word[idx];
          waitClk(HALF);
          cap[idx] = miso;
          sclk = cpol;
        end
        if (ackAtDone && b == 7 && w == nWords - 1) begin
          waitClk(4);
          rxAck = 1'b1;
          waitClk(1);
          rxAck = 1'b0;
          waitClk(HALF - 5);
        end else begin
          waitClk(HALF);
        end
        if (!cpha) sclk = cpol;
      end
      if (w == 0) m0 = cap;
      else m1 = cap;
    end
    waitClk(HALF);
    ss = 1'b0;
    waitClk(2 * HALF);
  endtask

  task automatic applyStimulus(input vec_t v);
    logic [7:0] m0, m1;
    cfg = v.cfg;
    loadTx(v.txWord);
    waitClk(3);
    checkOutput("idle_miso", miso, v.expIdleMiso);
    spiXfer(v.cfg, v.mosiWord, 8'h00, 1, 8, 1'b0, m0, m1);
    waitValid("rx_valid_set");
    checkOutput("rx_data", rxData, v.expRx);
    checkOutput("miso_word", m0, v.expMiso);
    checkOutput("no_overrun", overrun, 1'b0);
    ackRx();
  endtask

  initial begin
    logic [7:0] m0, m1;
    vecs[0] = '{cfg: 3'b001, txWord: 8'hC3, mosiWord: 8'hA5, expRx: 8'hA5, expMiso: 8'hC3, expIdleMiso: 1'b1};
    vecs[1] = '{cfg: 3'b110, txWord: 8'h81, mosiWord: 8'h3C, expRx: 8'h3C, expMiso: 8'h81, expIdleMiso: 1'b1};
    vecs[2] = '{cfg: 3'b101, txWord: 8'h69, mosiWord: 8'h4E, expRx: 8'h4E, expMiso: 8'h69, expIdleMiso: 1'b0};
    vecs[3] = '{cfg: 3'b010, txWord: 8'hF0, mosiWord: 8'hE1, expRx: 8'hE1, expMiso: 8'hF0, expIdleMiso: 1'b0};

    rst_n  = 1'b0;
    cfg    = 3'b001;
    sclk   = 1'b0;
    mosi   = 1'b0;
    ss     = 1'b0;
    txData = '0;
    txReq  = 1'b0;
    rxAck  = 1'b0;
    waitClk(4);
    rst_n = 1'b1;
    waitClk(4);

    checkOutput("reset_miso", miso, 1'b0);
    checkOutput("reset_tx_ack", txAck, 1'b0);
    checkOutput("reset_rx_valid", rxValid, 1'b0);
    checkOutput("reset_rx_data", rxData, 8'h00);
    checkOutput("reset_overrun", overrun, 1'b0);
`ifdef SPI_SLAVE_ERR_CNT_EN
    checkOutput("reset_err_cnt", errCnt, 8'd0);
`endif

    for (int i = 0; i < 4; i++) begin
      applyStimulus(vecs[i]);
    end
`ifdef SPI_SLAVE_ERR_CNT_EN
    checkOutput("err_cnt_clean_frames", errCnt, 8'd0);
`endif

    $display("[TB] abort after 5 bits");
    spiXfer(3'b001, 8'hFF, 8'h00, 1, 5, 1'b0, m0, m1);
    waitClk(20);
    checkOutput("abort_rx_valid", rxValid, 1'b0);
    checkOutput("abort_rx_data", rxData, 8'hE1);
    checkOutput("abort_overrun", overrun, 1'b0);
`ifdef SPI_SLAVE_ERR_CNT_EN
    checkOutput("abort_err_cnt", errCnt, 8'd1);
`endif
    spiXfer(3'b001, 8'h5A, 8'h00, 1, 8, 1'b0, m0, m1);
    waitValid("after_abort_valid");
    checkOutput("after_abort_data", rxData, 8'h5A);

    $display("[TB] rx_ack coincident with DONE");
    spiXfer(3'b001, 8'h77, 8'h00, 1, 8, 1'b1, m0, m1);
    checkOutput("ackdone_valid", rxValid, 1'b1);
    checkOutput("ackdone_data", rxData, 8'h77);
    checkOutput("ackdone_overrun", overrun, 1'b0);
    ackRx();

    $display("[TB] back-to-back words without ack");
    cfg = 3'b001;
    loadTx(8'hC3);
    spiXfer(3'b001, 8'h11, 8'h22, 2, 8, 1'b0, m0, m1);
    checkOutput("b2b_data", rxData, 8'h22);
    checkOutput("b2b_valid", rxValid, 1'b1);
    checkOutput("b2b_overrun", overrun, 1'b1);
    checkOutput("b2b_miso_w0", m0, 8'hC3);
    checkOutput("b2b_miso_w1", m1, 8'hC3);
`ifdef SPI_SLAVE_ERR_CNT_EN
    checkOutput("b2b_err_cnt", errCnt, 8'd2);
`endif

    $display("[TB] reset mid-frame");
    sclk = 1'b0;
    waitClk(HALF);
    ss = 1'b1;
    waitClk(2 * HALF);
    mosi = 1'b1;
    waitClk(HALF);
    sclk = 1'b1;
    waitClk(HALF);
    sclk = 1'b0;
    waitClk(HALF);
    rst_n = 1'b0;
    waitClk(1);
    checkOutput("midrst_miso", miso, 1'b0);
    checkOutput("midrst_tx_ack", txAck, 1'b0);
    checkOutput("midrst_rx_valid", rxValid, 1'b0);
    checkOutput("midrst_rx_data", rxData, 8'h00);
    checkOutput("midrst_overrun", overrun, 1'b0);
`ifdef SPI_SLAVE_ERR_CNT_EN
    checkOutput("midrst_err_cnt", errCnt, 8'd0);
`endif
    ss   = 1'b0;
    mosi = 1'b0;
    waitClk(4);
    rst_n = 1'b1;
    waitClk(4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
